// File: rtl/mcDefs.sv
// Shared definitions for the burst bus master: bus geometry, burst length and FSM states.
package mcDefs;

  localparam int unsigned BUSWIDTH  = 16;
  localparam int unsigned BURST_LEN = 4;
  localparam int unsigned WORDSW    = BUSWIDTH * BURST_LEN;

  typedef enum logic [2:0] {
    StWake,
    StIdle,
    StAddr,
    StData0,
    StData1,
    StData2,
    StData3,
    StTurn
  } mc_state_e;

  // Data-phase states are consecutive encodings, so the word index is an offset from StData0.
  function automatic logic [1:0] data_idx(input mc_state_e st);
    logic [2:0] d;
    d = 3'(st) - 3'(StData0);
    return d[1:0];
  endfunction

endpackage

// File: rtl/bus_master_ctrl_if.sv
// Shared multiplexed address/data main bus between the burst master and the memory slave.
interface bus_master_ctrl_if;

  logic                        AddrValid;
  logic                        busRw;
  logic [mcDefs::BUSWIDTH-1:0] AddrDataOut;
  logic                        AddrDataOe;
  logic [mcDefs::BUSWIDTH-1:0] AddrDataIn;

  modport master (
    output AddrValid,
    output busRw,
    output AddrDataOut,
    output AddrDataOe,
    input  AddrDataIn
  );

  modport slave (
    input  AddrValid,
    input  busRw,
    input  AddrDataOut,
    input  AddrDataOe,
    output AddrDataIn
  );

endinterface

// File: rtl/page_range_chk.sv
// Page window comparator; only instantiated when ADDR_RANGE_CHECK_EN is defined.
module page_range_chk #(
  parameter logic [3:0] PAGE_LO = 4'h0,
  parameter logic [3:0] PAGE_HI = 4'hF
) (
  input  logic [3:0] page,
  output logic       in_range
);

  assign in_range = (page >= PAGE_LO) && (page <= PAGE_HI);

endmodule

// File: rtl/bus_master_ctrl.sv
// Four-word burst master on a multiplexed address/data bus.
// Optional page range rejection is enabled by defining ADDR_RANGE_CHECK_EN.
module bus_master_ctrl
  import mcDefs::*;
#(
  parameter logic [3:0] PAGE_LO = 4'h0,
  parameter logic [3:0] PAGE_HI = 4'hF
) (
  input  logic                clk,
  input  logic                resetL,
  input  logic                req,
  input  logic                rw,
  input  logic [15:0]         addr,
  input  logic [WORDSW-1:0]   wrData,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [WORDSW-1:0]   rdData,
  bus_master_ctrl_if.master   bus
);

  mc_state_e             state_q, state_d;
  logic                  rw_q;
  logic [BUSWIDTH-1:0]   addr_q;
  logic [WORDSW-1:0]     wr_q;
  logic [WORDSW-1:0]     rd_q;
  logic                  page_ok;
  logic                  accept;
  logic                  is_data;

`ifdef ADDR_RANGE_CHECK_EN
  logic err_q;

  page_range_chk #(
    .PAGE_LO (PAGE_LO),
    .PAGE_HI (PAGE_HI)
  ) u_page_range_chk (
    .page     (addr[15:12]),
    .in_range (page_ok)
  );

  // Rejected requests never leave IDLE; err is a registered one-cycle flag.
  always_ff @(posedge clk or negedge resetL) begin
    if (!resetL) err_q <= 1'b0;
    else         err_q <= (state_q == StIdle) && req && !page_ok;
  end

  assign err = err_q;
`else
  logic unused_page_cfg;

  assign page_ok         = 1'b1;
  assign err             = 1'b0;
  assign unused_page_cfg = ^{PAGE_LO, PAGE_HI};
`endif

  assign accept  = (state_q == StIdle) && req && page_ok;
  assign is_data = state_q inside {StData0, StData1, StData2, StData3};
  assign rdData  = rd_q;

  always_ff @(posedge clk or negedge resetL) begin
    if (!resetL) state_q <= StWake;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StWake:  state_d = StIdle;
      StIdle:  if (accept) state_d = StAddr;
      StAddr:  state_d = StData0;
      StData0: state_d = StData1;
      StData1: state_d = StData2;
      StData2: state_d = StData3;
      StData3: state_d = StTurn;
      StTurn:  state_d = StIdle;
      default: state_d = StWake;
    endcase
  end

  always_comb begin
    busy            = 1'b0;
    done            = 1'b0;
    bus.AddrValid   = 1'b0;
    bus.busRw       = 1'b0;
    bus.AddrDataOut = '0;
    bus.AddrDataOe  = 1'b0;
    unique case (state_q)
      StAddr: begin
        busy            = 1'b1;
        bus.AddrValid   = 1'b1;
        bus.busRw       = rw_q;
        bus.AddrDataOut = addr_q;
        bus.AddrDataOe  = 1'b1;
      end
      StData0, StData1, StData2, StData3: begin
        busy = 1'b1;
        if (!rw_q) begin
          bus.AddrDataOut = wr_q[data_idx(state_q)*BUSWIDTH +: BUSWIDTH];
          bus.AddrDataOe  = 1'b1;
        end
      end
      StTurn:  done = 1'b1;
      default: ;
    endcase
  end

  // Request fields are frozen at accept; the slave forms base+k itself.
  always_ff @(posedge clk or negedge resetL) begin
    if (!resetL) begin
      rw_q   <= 1'b0;
      addr_q <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
    end else begin
      if (accept) begin
        rw_q   <= rw;
        addr_q <= addr;
        wr_q   <= wrData;
      end
      if (is_data && rw_q) begin
        rd_q[data_idx(state_q)*BUSWIDTH +: BUSWIDTH] <= bus.AddrDataIn;
      end
    end
  end

endmodule

// File: tb/tb_bus_master_ctrl.sv
// Directed bench for bus_master_ctrl with a behavioural memory slave on the shared bus.
module tb_bus_master_ctrl;

  logic        clk = 1'b0;
  logic        resetL = 1'b0;
  logic        req = 1'b0;
  logic        rw = 1'b0;
  logic [15:0] addr = '0;
  logic [63:0] wrData = '0;
  logic        busy, done, err;
  logic [63:0] rdData;

  bus_master_ctrl_if bus ();

  bus_master_ctrl #(
    .PAGE_LO (4'h2),
    .PAGE_HI (4'h2)
  ) dut (
    .clk    (clk),
    .resetL (resetL),
    .req    (req),
    .rw     (rw),
    .addr   (addr),
    .wrData (wrData),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .rdData (rdData),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Memory slave: latches the base on AddrValid, then serves base+k (mod 4096) for 4 cycles.
  logic [15:0] mem [0:65535];
  logic [2:0]  s_cnt;
  logic        s_rw;
  logic [15:0] s_base;

  function automatic logic [15:0] word_addr(input logic [15:0] base, input logic [2:0] cnt);
    logic [11:0] off;
    off = base[11:0] + 12'(cnt - 3'd1);
    return {base[15:12], off};
  endfunction

  always @(posedge clk or negedge resetL) begin
    if (!resetL) begin
      s_cnt  <= 3'd0;
      s_rw   <= 1'b0;
      s_base <= 16'h0;
    end else if (bus.AddrValid) begin
      s_base <= bus.AddrDataOut;
      s_rw   <= bus.busRw;
      s_cnt  <= 3'd1;
    end else if (s_cnt != 3'd0) begin
      if (!s_rw) mem[word_addr(s_base, s_cnt)] <= bus.AddrDataOut;
      s_cnt <= (s_cnt == 3'd4) ? 3'd0 : s_cnt + 3'd1;
    end
  end

  assign bus.AddrDataIn = bus.AddrDataOe ? bus.AddrDataOut :
                          (s_cnt != 3'd0 && s_rw) ? mem[word_addr(s_base, s_cnt)] : 16'h0;

  int cyc = 0;
  int done_cnt = 0;
  int err_seen = 0;
  int oe_viol = 0;
  int av_times[$];

  always @(negedge clk) begin
    cyc++;
    if (bus.AddrValid) av_times.push_back(cyc);
    if (done) done_cnt++;
    if (err) err_seen++;
    if (s_cnt != 3'd0 && s_rw && bus.AddrDataOe) oe_viol++;
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_strobe(input string tag, output bit ok);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.AddrValid && n < 20);
    ok = bus.AddrValid;
    if (!ok) check({tag, " strobe timeout"}, 64'd0, 64'd1);
  endtask

  task automatic run_burst(input string tag, input logic r, input logic [15:0] a,
                           input logic [63:0] d);
    bit ok;
    req = 1'b1; rw = r; addr = a; wrData = d;
    wait_strobe(tag, ok);
    req = 1'b0;
    if (!ok) return;
    check({tag, " addr"}, bus.AddrDataOut, a);
    check({tag, " busRw"}, bus.busRw, r);
    check({tag, " addr oe"}, bus.AddrDataOe, 1'b1);
    check({tag, " addr busy"}, busy, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("%s d%0d av", tag, k), bus.AddrValid, 1'b0);
      check($sformatf("%s d%0d oe", tag, k), bus.AddrDataOe, !r);
      check($sformatf("%s d%0d busy", tag, k), busy, 1'b1);
      check($sformatf("%s d%0d done", tag, k), done, 1'b0);
      if (!r) check($sformatf("%s d%0d word", tag, k), bus.AddrDataOut, d[k*16 +: 16]);
    end
    @(negedge clk);
    check({tag, " turn done"}, done, 1'b1);
    check({tag, " turn busy"}, busy, 1'b0);
    check({tag, " turn oe"}, bus.AddrDataOe, 1'b0);
    check({tag, " turn av"}, bus.AddrValid, 1'b0);
    @(negedge clk);
    check({tag, " idle done"}, done, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int dc;

    repeat (3) @(negedge clk);
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst err", err, 1'b0);
    check("rst av", bus.AddrValid, 1'b0);
    check("rst busRw", bus.busRw, 1'b0);
    check("rst oe", bus.AddrDataOe, 1'b0);
    check("rst out", bus.AddrDataOut, 16'h0);
    check("rst rdData", rdData, 64'h0);
    resetL = 1'b1;

    run_burst("wr2010", 1'b0, 16'h2010, 64'h4444_3333_2222_1111);
    check("mem 2010", mem[16'h2010], 16'h1111);
    check("mem 2011", mem[16'h2011], 16'h2222);
    check("mem 2012", mem[16'h2012], 16'h3333);
    check("mem 2013", mem[16'h2013], 16'h4444);

    run_burst("rd2010", 1'b1, 16'h2010, 64'h0);
    check("rd2010 rdData", rdData, 64'h4444_3333_2222_1111);

    // req held high: back-to-back reads every 7 cycles
    av_times.delete();
    req = 1'b1; rw = 1'b1; addr = 16'h2010;
    repeat (18) @(negedge clk);
    req = 1'b0;
    repeat (3) @(negedge clk);
    check("hold strobes", av_times.size(), 3);
    if (av_times.size() >= 3) begin
      check("hold gap1", av_times[1] - av_times[0], 7);
      check("hold gap2", av_times[2] - av_times[1], 7);
    end
    check("hold rdData", rdData, 64'h4444_3333_2222_1111);

    run_burst("wrap wr", 1'b0, 16'h2FFE, 64'h8888_7777_6666_5555);
    check("wr keeps rdData", rdData, 64'h4444_3333_2222_1111);
    check("mem 2FFE", mem[16'h2FFE], 16'h5555);
    check("mem 2FFF", mem[16'h2FFF], 16'h6666);
    check("mem 2000", mem[16'h2000], 16'h7777);
    check("mem 2001", mem[16'h2001], 16'h8888);
    run_burst("wrap rd", 1'b1, 16'h2FFE, 64'h0);
    check("wrap rdData", rdData, 64'h8888_7777_6666_5555);

`ifdef ADDR_RANGE_CHECK_EN
    req = 1'b1; rw = 1'b0; addr = 16'h3000;
    @(negedge clk);
    check("range err", err, 1'b1);
    check("range busy", busy, 1'b0);
    check("range av", bus.AddrValid, 1'b0);
    req = 1'b0;
    @(negedge clk);
    check("range err pulse", err, 1'b0);
    check("range busy2", busy, 1'b0);
    check("range av2", bus.AddrValid, 1'b0);
`else
    run_burst("pg3 wr", 1'b0, 16'h3000, 64'h0D0C_0B0A_0908_0706);
    check("mem 3000", mem[16'h3000], 16'h0706);
    check("mem 3003", mem[16'h3003], 16'h0D0C);
`endif

    // Reset asserted during DATA1 of a write
    req = 1'b1; rw = 1'b0; addr = 16'h2050; wrData = 64'hDDDD_CCCC_BBBB_AAAA;
    wait_strobe("midrst", ok);
    req = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst in burst", busy, 1'b1);
    dc = done_cnt;
    resetL = 1'b0;
    #1;
    check("midrst busy", busy, 1'b0);
    check("midrst done", done, 1'b0);
    check("midrst oe", bus.AddrDataOe, 1'b0);
    check("midrst out", bus.AddrDataOut, 16'h0);
    check("midrst av", bus.AddrValid, 1'b0);
    check("midrst rdData", rdData, 64'h0);
    repeat (2) @(negedge clk);
    resetL = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst no done", done_cnt, dc);
    run_burst("post rst wr", 1'b0, 16'h2020, 64'h1234_5678_9ABC_DEF0);
    check("mem 2020", mem[16'h2020], 16'hDEF0);
    check("mem 2023", mem[16'h2023], 16'h1234);

    check("read phase oe", oe_viol, 0);
`ifdef ADDR_RANGE_CHECK_EN
    check("err cycles", err_seen, 1);
`else
    check("err cycles", err_seen, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
